wide_add_sequencer: RTL and testbench

//   Multi-cycle controller that adds two NWORDS*WORD_W-bit operands by driving the

---
 rtl/wide_add_sequencer.sv | 137 +++++++++++++
 tb/tb_wide_add_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Sequencer that adds two NWORDS*WORD_W-bit operands through an external
// combinational hybrid_adder, one WORD_W-bit slice per cycle, LSW first.
module wide_add_sequencer #(
  parameter int WORD_W  = 18,
  parameter int NWORDS  = 4,
  parameter int CARRY_W = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NWORDS*WORD_W-1:0]   op_a,
  input  logic [NWORDS*WORD_W-1:0]   op_b,
  input  logic                       cin,
  output logic                       busy,
  output logic                       done,
  output logic [NWORDS*WORD_W-1:0]   sum,
  output logic                       cout,
  output logic [WORD_W-1:0]          add_a,
  output logic [WORD_W-1:0]          add_b,
  output logic                       add_c0,
  input  logic [WORD_W-1:0]          add_s,
  input  logic [CARRY_W-1:0]         add_c
);

  localparam int TOTAL_W = NWORDS * WORD_W;
  localparam int IDX_W   = $clog2(NWORDS) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [TOTAL_W-1:0] a_q, a_d;
  logic [TOTAL_W-1:0] b_q, b_d;
  logic [TOTAL_W-1:0] sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic slice_co;
  logic unused_carry_bits;

  // Only the top bit of the adder's carry bus is the slice carry-out.
  assign slice_co          = add_c[CARRY_W-1];
  assign unused_carry_bits = ^add_c;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = op_a;
          b_d     = op_b;
          carry_d = cin;
          idx_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*WORD_W +: WORD_W] = add_s;
        carry_d = slice_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_co;
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Adder inputs are quiet outside RUN so the external adder sees no activity.
  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_c0 = 1'b0;
    if (state_q == RUN) begin
      add_a  = a_q[int'(idx_q)*WORD_W +: WORD_W];
      add_b  = b_q[int'(idx_q)*WORD_W +: WORD_W];
      add_c0 = carry_q;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench for wide_add_sequencer: models the hybrid_adder and
// compares every result against plain wide-integer addition.
module tb_wide_add_sequencer;

  localparam int WORD_W  = 18;
  localparam int NWORDS  = 4;
  localparam int CARRY_W = 5;
  localparam int TOTAL_W = NWORDS * WORD_W;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [TOTAL_W-1:0] op_a;
  logic [TOTAL_W-1:0] op_b;
  logic               cin;
  logic               busy;
  logic               done;
  logic [TOTAL_W-1:0] sum;
  logic               cout;
  logic [WORD_W-1:0]  add_a;
  logic [WORD_W-1:0]  add_b;
  logic               add_c0;
  logic [WORD_W-1:0]  add_s;
  logic [CARRY_W-1:0] add_c;
  logic [WORD_W:0]    ha_full;

  int checks = 0;
  int errors = 0;

  wide_add_sequencer #(
    .WORD_W (WORD_W),
    .NWORDS (NWORDS),
    .CARRY_W(CARRY_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op_a  (op_a),
    .op_b  (op_b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .add_a (add_a),
    .add_b (add_b),
    .add_c0(add_c0),
    .add_s (add_s),
    .add_c (add_c)
  );

  always #5 clk = ~clk;

  // Adder stand-in: lower carry bits are driven opposite to the carry-out so
  // that only c[CARRY_W-1] can give the correct chaining.
  always_comb begin
    ha_full = {1'b0, add_a} + {1'b0, add_b} + {{WORD_W{1'b0}}, add_c0};
    add_s   = ha_full[WORD_W-1:0];
    add_c   = {ha_full[WORD_W], {(CARRY_W-1){~ha_full[WORD_W]}}};
  end

  task automatic checkOutput(input string tag, input logic [TOTAL_W:0] got,
                             input logic [TOTAL_W:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [TOTAL_W:0] refSum(input logic [TOTAL_W-1:0] a,
                                              input logic [TOTAL_W-1:0] b,
                                              input logic c);
    return {1'b0, a} + {1'b0, b} + (TOTAL_W+1)'(c);
  endfunction

  // Carry entering slice k = carry out of the low k*WORD_W bits of the sum.
  function automatic logic refCarryIn(input logic [TOTAL_W-1:0] a,
                                      input logic [TOTAL_W-1:0] b,
                                      input logic c, input int k);
    logic [TOTAL_W:0] mask;
    logic [TOTAL_W:0] t;
    if (k == 0) return c;
    mask = ((TOTAL_W+1)'(1) << (k * WORD_W)) - 1'b1;
    t = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (TOTAL_W+1)'(c);
    return t[k*WORD_W];
  endfunction

  // Issues one start and samples each following cycle until done is seen.
  task automatic applyStimulus(input logic [TOTAL_W-1:0] a, input logic [TOTAL_W-1:0] b,
                               input logic c, output int doneCycle,
                               output logic [NWORDS-1:0] c0Hist);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    cin   = c;
    start = 1'b1;
    doneCycle = -1;
    c0Hist    = '0;
    for (int k = 1; k <= NWORDS + 4 && doneCycle < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k <= NWORDS) c0Hist[k-1] = add_c0;
      if (done) doneCycle = k;
    end
  endtask

  task automatic checkOp(input string tag, input logic [TOTAL_W-1:0] a,
                         input logic [TOTAL_W-1:0] b, input logic c,
                         output logic [NWORDS-1:0] c0Hist);
    int doneCycle;
    logic [NWORDS-1:0] expC0;
    logic [TOTAL_W:0] expRes;
    applyStimulus(a, b, c, doneCycle, c0Hist);
    expRes = refSum(a, b, c);
    for (int k = 0; k < NWORDS; k++) expC0[k] = refCarryIn(a, b, c, k);
    checkOutput({tag, "_done_cycle"}, (TOTAL_W+1)'(doneCycle), (TOTAL_W+1)'(NWORDS + 1));
    checkOutput({tag, "_result"}, {cout, sum}, expRes);
    checkOutput({tag, "_c0_chain"}, (TOTAL_W+1)'(c0Hist), (TOTAL_W+1)'(expC0));
    @(negedge clk);
    checkOutput({tag, "_after_done"}, (TOTAL_W+1)'({done, busy}), '0);
    checkOutput({tag, "_hold"}, {cout, sum}, expRes);
  endtask

  initial begin
    logic [NWORDS-1:0] c0Hist;
    logic [TOTAL_W-1:0] ra, rb;
    logic [95:0] rnd;
    logic [TOTAL_W:0] firstRes;
    logic [TOTAL_W:0] seenRes;
    int doneCount;

    rst   = 1'b1;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    cin   = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_flags", (TOTAL_W+1)'({busy, done, cout}), '0);
    checkOutput("reset_sum", {1'b0, sum}, '0);
    checkOutput("reset_adder_if", (TOTAL_W+1)'({add_a, add_b, add_c0}), '0);
    rst = 1'b0;

    checkOp("small", TOTAL_W'(128), TOTAL_W'(128), 1'b0, c0Hist);
    checkOutput("small_sum", {cout, sum}, (TOTAL_W+1)'(256));

    checkOp("all_ones", '1, '0, 1'b1, c0Hist);
    checkOutput("all_ones_c0", (TOTAL_W+1)'(c0Hist), (TOTAL_W+1)'({NWORDS{1'b1}}));
    checkOutput("all_ones_sum", {cout, sum}, {1'b1, {TOTAL_W{1'b0}}});

    checkOp("slice_carry", TOTAL_W'(18'h3FFFF), TOTAL_W'(1), 1'b0, c0Hist);
    checkOutput("slice_carry_c0", (TOTAL_W+1)'(c0Hist), (TOTAL_W+1)'(4'b0010));
    checkOutput("slice_carry_sum", {cout, sum}, (TOTAL_W+1)'(20'h40000));

    // start re-pulsed in the middle of RUN must be ignored
    @(negedge clk);
    op_a  = TOTAL_W'(72'h12_3456_789A_BCDE_F012);
    op_b  = TOTAL_W'(72'hFE_DCBA_9876_5432_10FF);
    cin   = 1'b1;
    firstRes = refSum(op_a, op_b, cin);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    op_a  = '1;
    op_b  = '1;
    cin   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCount = 0;
    seenRes   = '0;
    for (int i = 0; i < 8; i++) begin
      if (done) begin
        doneCount++;
        seenRes = {cout, sum};
      end
      @(negedge clk);
    end
    checkOutput("restart_done_count", (TOTAL_W+1)'(doneCount), (TOTAL_W+1)'(1));
    checkOutput("restart_result", seenRes, firstRes);

    // reset during RUN at idx 2 discards the partial result
    @(negedge clk);
    op_a  = '1;
    op_b  = '1;
    cin   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrun_reset_flags", (TOTAL_W+1)'({busy, done, cout}), '0);
    checkOutput("midrun_reset_sum", {1'b0, sum}, '0);
    checkOp("after_reset", TOTAL_W'(72'h55_AAAA_5555_AAAA_5555), TOTAL_W'(72'hAA_5555_AAAA_5555_AAAB),
            1'b0, c0Hist);

    for (int n = 0; n < 500; n++) begin
      rnd = {$urandom, $urandom, $urandom};
      ra  = rnd[TOTAL_W-1:0];
      rnd = {$urandom, $urandom, $urandom};
      rb  = rnd[TOTAL_W-1:0];
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      checkOp("random", ra, rb, 1'($urandom_range(0, 1)), c0Hist);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
